// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default baud/oversample constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // 50 MHz system clock, 19200 baud, 16x oversampling.
    localparam int UART_CLK_DIV    = 163;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_START_MID  = UART_OVERSAMPLE / 2 - 1;
    localparam int UART_BIT_LAST   = UART_OVERSAMPLE - 1;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on o_rdata while o_empty=0.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DW     = 8,
    parameter int FIFO_W = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic          o_empty,
    output logic          o_full
);

    localparam int DEPTH = 1 << FIFO_W;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [FIFO_W:0] r_wr_ptr;
    logic [FIFO_W:0] r_rd_ptr;
    logic            w_do_pop;
    logic            w_do_push;

    // The extra MSB on each pointer distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[FIFO_W] != r_rd_ptr[FIFO_W]) &&
                       (r_wr_ptr[FIFO_W-1:0] == r_rd_ptr[FIFO_W-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[FIFO_W-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[FIFO_W-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_buf.sv
// 16x oversampled 8N1 UART receiver feeding a FWFT byte FIFO.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx_buf
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int CLK_DIV = UART_CLK_DIV,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            overrun,
    output logic            parity_err
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic            r_rx_meta;
    logic            r_rx_sync;
    logic [CW-1:0]   r_tick_cnt;
    logic            w_s_tick;
    rx_state_t       r_state;
    logic [3:0]      r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_shift;
    logic            r_frame_err;
    logic            r_overrun;
    logic            w_stop_done;
    logic            w_par_ok;
    logic            w_push;
    logic            w_full;
    logic            w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_tick_cnt <= '0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_tick_cnt <= w_s_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    assign w_s_tick    = (r_tick_cnt == CW'(CLK_DIV - 1));
    assign w_stop_done = (r_state == ST_STOP) && w_s_tick && (r_s == 4'(SB_TICK - 1));

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
    assign w_par_ok   = ~(^{r_shift, r_par_bit});
    assign parity_err = r_parity_err;
`else
    assign w_par_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    assign w_push = w_stop_done & r_rx_sync & w_par_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                    end
                end
                ST_START: begin
                    if (w_s_tick) begin
                        // Mid-start-bit check: a line already back high was only a glitch.
                        if (r_s == 4'(UART_START_MID)) begin
                            if (!r_rx_sync) begin
                                r_state <= ST_DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_s_tick) begin
                        if (r_s == 4'(UART_BIT_LAST)) begin
                            r_shift <= {r_rx_sync, r_shift[DBIT-1:1]};
                            r_s     <= '0;
                            if (r_n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_s_tick) begin
                        if (r_s == 4'(UART_BIT_LAST)) begin
                            r_par_bit <= r_rx_sync;
                            r_s       <= '0;
                            r_state   <= ST_STOP;
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (w_s_tick) begin
                        if (r_s == 4'(SB_TICK - 1)) begin
                            // Framing error outranks parity error; the push itself is decoded from w_push.
                            if (!r_rx_sync) begin
                                r_frame_err <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            else if (!w_par_ok) begin
                                r_parity_err <= 1'b1;
                            end
`endif
                            r_state <= ST_IDLE;
                            r_s     <= '0;
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A simultaneous pop frees the slot, so a push into a full FIFO is only lost without one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push & w_full & ~rd_uart;
        end
    end

    uart_fifo #(
        .DW     (DBIT),
        .FIFO_W (FIFO_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_pop   (rd_uart),
        .i_wdata (r_shift),
        .o_rdata (r_data),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign rx_empty  = w_empty;
    assign rx_full   = w_full;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf with a queue-based model of the byte FIFO and error pulses.
// Honours UART_RX_PARITY_EN in the same way as the design.
module tb_uart_rx_buf;
    import uart_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int DBIT     = 8;
    localparam int FIFO_W   = 2;
    localparam int DEPTH    = 4;
    localparam int BIT_CLKS = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN      = 1'b1;
    localparam int FRAME_TICKS = 8 + 16 * DBIT + 16 + 16;
`else
    localparam bit PAR_EN      = 1'b0;
    localparam int FRAME_TICKS = 8 + 16 * DBIT + 16;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rd_uart = 1'b0;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    always #5 clk = ~clk;

    uart_rx_buf #(
        .DBIT    (DBIT),
        .SB_TICK (16),
        .CLK_DIV (CLK_DIV),
        .FIFO_W  (FIFO_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd_uart    (rd_uart),
        .r_data     (r_data),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int reset_cyc = 0;
    int push_cyc = -1;
    int cnt_ferr = 0, cnt_ovr = 0, cnt_perr = 0;
    int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
    logic prev_empty = 1'b1;
    logic [7:0] exp_q[$];
    bit         exp_pop_valid;
    logic [7:0] exp_pop_data;
    int         last_pe;
    logic [7:0] last_pop_data;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and the edge at which the FIFO last went non-empty.
    always @(negedge clk) begin
        if (frame_err === 1'b1) cnt_ferr++;
        if (overrun === 1'b1) cnt_ovr++;
        if (parity_err === 1'b1) cnt_perr++;
        if (prev_empty === 1'b1 && rx_empty === 1'b0) push_cyc = cyc;
        prev_empty = rx_empty;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        rx = 1'b1;
        rd_uart = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset_cyc = cyc;
        reset = 1'b0;
    endtask

    task automatic do_pop();
        rd_uart = 1'b1;
        @(posedge clk); #1;
        rd_uart = 1'b0;
    endtask

    // Drives one frame. The tick phase is fixed by the last reset, so the push edge is predictable.
    task automatic send_frame(input logic [7:0] d, input bit good_stop, input bit bad_par, input bit pop_at_push);
        logic bits [11];
        int nb, start_cyc, e0, t1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        nb = 9;
        if (PAR_EN) begin
            bits[9] = (^d) ^ bad_par;
            nb = 10;
        end
        @(posedge clk); #1;
        rx = 1'b0;
        start_cyc = cyc;
        e0 = start_cyc + 3;
        t1 = reset_cyc + CLK_DIV * ((e0 - reset_cyc) / CLK_DIV + 1);
        last_pe = t1 + (FRAME_TICKS - 1) * CLK_DIV;
        fork
            begin
                for (int i = 0; i < nb; i++) begin
                    rx = bits[i];
                    repeat (BIT_CLKS) @(posedge clk);
                    #1;
                end
                if (good_stop) begin
                    rx = 1'b1;
                    repeat (BIT_CLKS) @(posedge clk);
                    #1;
                end else begin
                    rx = 1'b0;
                    repeat (40) @(posedge clk);
                    #1;
                    rx = 1'b1;
                    repeat (BIT_CLKS - 40) @(posedge clk);
                    #1;
                end
                rx = 1'b1;
                repeat (BIT_CLKS) @(posedge clk);
                #1;
            end
            begin
                if (pop_at_push) begin
                    while (cyc < last_pe - 1) begin
                        @(posedge clk); #1;
                    end
                    last_pop_data = r_data;
                    do_pop();
                end
            end
        join
    endtask

    task automatic model_apply(input logic [7:0] d, input bit good_stop, input bit bad_par, input bit pop);
        exp_pop_valid = 1'b0;
        if (pop && exp_q.size() > 0) begin
            exp_pop_valid = 1'b1;
            exp_pop_data = exp_q.pop_front();
        end
        if (!good_stop) exp_ferr++;
        else if (PAR_EN && bad_par) exp_perr++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ovr++;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", rx_empty); end
        n_cmp++; if (rx_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", rx_full); end
        n_cmp++; if (r_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", r_data); end
        n_cmp++; if ({frame_err, overrun, parity_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {frame_err, overrun, parity_err}); end
    endtask

    task automatic test_single();
        push_cyc = -1;
        send_frame(8'h35, 1'b1, 1'b0, 1'b0);
        model_apply(8'h35, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (push_cyc !== last_pe) begin n_bad++; $display("FAIL single_latency: got edge %0d want %0d", push_cyc, last_pe); end
        n_cmp++; if (rx_empty !== 1'b0) begin n_bad++; $display("FAIL single_empty: got %b want 0", rx_empty); end
        n_cmp++; if (r_data !== exp_q[0]) begin n_bad++; $display("FAIL single_data: got %h want %h", r_data, exp_q[0]); end
        do_pop();
        void'(exp_q.pop_front());
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL single_pop_empty: got %b want 1", rx_empty); end
    endtask

    task automatic test_glitch();
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (3 * CLK_DIV) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (160) @(posedge clk);
        #1;
        n_cmp++; if (cnt_ferr !== exp_ferr) begin n_bad++; $display("FAIL glitch_ferr: got %0d want %0d", cnt_ferr, exp_ferr); end
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL glitch_empty: got %b want 1", rx_empty); end
        n_cmp++; if (dut.r_state !== ST_IDLE) begin n_bad++; $display("FAIL glitch_state: got %0d want %0d", dut.r_state, ST_IDLE); end
    endtask

    task automatic test_frame_err();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        model_apply(8'hA5, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (cnt_ferr !== exp_ferr) begin n_bad++; $display("FAIL ferr_count: got %0d want %0d", cnt_ferr, exp_ferr); end
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL ferr_empty: got %b want 1", rx_empty); end
    endtask

    task automatic test_overrun();
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, 1'b0, 1'b0);
            model_apply(8'(k), 1'b1, 1'b0, 1'b0);
            n_cmp++; if (rx_full !== (exp_q.size() == DEPTH)) begin n_bad++; $display("FAIL ovr_full_%0d: got %b want %b", k, rx_full, exp_q.size() == DEPTH); end
        end
        n_cmp++; if (cnt_ovr !== exp_ovr) begin n_bad++; $display("FAIL ovr_count: got %0d want %0d", cnt_ovr, exp_ovr); end
        n_cmp++; if (r_data !== exp_q[0]) begin n_bad++; $display("FAIL ovr_head: got %h want %h", r_data, exp_q[0]); end
    endtask

    task automatic test_full_pop_push();
        send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
        model_apply(8'h7E, 1'b1, 1'b0, 1'b1);
        if (exp_pop_valid) begin
            n_cmp++; if (last_pop_data !== exp_pop_data) begin n_bad++; $display("FAIL fullpop_popped: got %h want %h", last_pop_data, exp_pop_data); end
        end
        n_cmp++; if (cnt_ovr !== exp_ovr) begin n_bad++; $display("FAIL fullpop_ovr: got %0d want %0d", cnt_ovr, exp_ovr); end
        n_cmp++; if (rx_full !== 1'b1) begin n_bad++; $display("FAIL fullpop_full: got %b want 1", rx_full); end
        while (exp_q.size() > 0) begin
            n_cmp++; if (r_data !== exp_q[0] || rx_empty !== 1'b0) begin n_bad++; $display("FAIL fullpop_drain: got %h/empty=%b want %h", r_data, rx_empty, exp_q[0]); end
            do_pop();
            void'(exp_q.pop_front());
        end
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL fullpop_end_empty: got %b want 1", rx_empty); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        model_apply(8'h11, 1'b1, 1'b0, 1'b0);
        v = 8'h5A;
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 rx = v[i];
            repeat (BIT_CLKS) @(posedge clk);
        end
        do_reset();
        exp_q.delete();
        n_cmp++; if (rx_empty !== 1'b1 || rx_full !== 1'b0) begin n_bad++; $display("FAIL rstmid_flags: got empty=%b full=%b want 1/0", rx_empty, rx_full); end
        n_cmp++; if (r_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", r_data); end
        n_cmp++; if (dut.r_state !== ST_IDLE) begin n_bad++; $display("FAIL rstmid_state: got %0d want %0d", dut.r_state, ST_IDLE); end
        push_cyc = -1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        model_apply(8'h3C, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (push_cyc !== last_pe) begin n_bad++; $display("FAIL rstmid_latency: got edge %0d want %0d", push_cyc, last_pe); end
        n_cmp++; if (r_data !== exp_q[0]) begin n_bad++; $display("FAIL rstmid_next: got %h want %h", r_data, exp_q[0]); end
        do_pop();
        void'(exp_q.pop_front());
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        model_apply(8'h07, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (cnt_perr !== exp_perr) begin n_bad++; $display("FAIL par_err_count: got %0d want %0d", cnt_perr, exp_perr); end
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL par_err_nopush: got %b want 1", rx_empty); end
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        model_apply(8'h07, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (r_data !== 8'h07 || rx_empty !== 1'b0) begin n_bad++; $display("FAIL par_ok_data: got %h/empty=%b want 07", r_data, rx_empty); end
        do_pop();
        void'(exp_q.pop_front());
    endtask
`endif

    task automatic test_random();
        logic [7:0] d;
        bit gs, bp, pp;
        for (int f = 0; f < 14; f++) begin
            d  = 8'($urandom_range(0, 255));
            gs = ($urandom_range(0, 5) != 0);
            bp = PAR_EN && ($urandom_range(0, 3) == 0);
            pp = ($urandom_range(0, 1) == 1);
            send_frame(d, gs, bp, pp);
            model_apply(d, gs, bp, pp);
            if (exp_pop_valid) begin
                n_cmp++; if (last_pop_data !== exp_pop_data) begin n_bad++; $display("FAIL rnd_popped_%0d: got %h want %h", f, last_pop_data, exp_pop_data); end
            end
            n_cmp++; if (rx_empty !== (exp_q.size() == 0) || rx_full !== (exp_q.size() == DEPTH)) begin n_bad++; $display("FAIL rnd_flags_%0d: got empty=%b full=%b want size %0d", f, rx_empty, rx_full, exp_q.size()); end
            n_cmp++; if (r_data !== ((exp_q.size() > 0) ? exp_q[0] : 8'h00)) begin n_bad++; $display("FAIL rnd_head_%0d: got %h want size %0d", f, r_data, exp_q.size()); end
            n_cmp++; if (cnt_ferr !== exp_ferr || cnt_ovr !== exp_ovr || cnt_perr !== exp_perr) begin n_bad++; $display("FAIL rnd_pulses_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", f, cnt_ferr, cnt_ovr, cnt_perr, exp_ferr, exp_ovr, exp_perr); end
            if ($urandom_range(0, 2) == 0) begin
                while (exp_q.size() > 0) begin
                    n_cmp++; if (r_data !== exp_q[0]) begin n_bad++; $display("FAIL rnd_drain_%0d: got %h want %h", f, r_data, exp_q[0]); end
                    do_pop();
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_pop_push();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
